// File: rtl/icache_ctrl_pkg.sv
// Shared definitions for the L1 instruction-cache controller: FSM states,
// tag layout, RAM read/write encoding and address field helpers.
package icache_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_ACCESS = 2'd0,
        ST_L2_REQ = 2'd1,
        ST_FILL   = 2'd2,
        ST_WAIT   = 2'd3
    } state_e;

    localparam int TAG_W         = 21;
    localparam int TAG_VALID_BIT = 20;
    localparam int TAG_ADDR_W    = 20;

    // RAM port direction encoding shared with itag_ram/data_ram
    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

    function automatic logic [TAG_ADDR_W-1:0] addr_tag(input logic [31:0] a);
        return a[31:12];
    endfunction

    function automatic logic [7:0] addr_index(input logic [31:0] a);
        return a[11:4];
    endfunction

    function automatic logic [1:0] addr_word(input logic [31:0] a);
        return a[3:2];
    endfunction

    // A way hits when its tag is valid and matches the address tag field
    function automatic logic tag_hit(input logic [TAG_W-1:0] t, input logic [31:0] a);
        return t[TAG_VALID_BIT] && (t[TAG_ADDR_W-1:0] == addr_tag(a));
    endfunction

    // Word 0 sits in the least significant 32 bits of the line
    function automatic logic [31:0] line_word(input logic [127:0] line, input logic [1:0] w);
        logic [31:0] word;
        case (w)
            2'd0:    word = line[31:0];
            2'd1:    word = line[63:32];
            2'd2:    word = line[95:64];
            2'd3:    word = line[127:96];
            default: word = line[31:0];
        endcase
        return word;
    endfunction

endpackage

// File: rtl/icache_ctrl_sat_cnt.sv
// Saturating event counter used for the hit/miss performance counters.
// Once all-ones is reached the value holds until reset.
module icache_sat_cnt #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] cnt_r;

    // Count events, sticking at the maximum value instead of wrapping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (inc && (cnt_r != CNT_MAX)) begin
            cnt_r <= cnt_r + CNT_ONE;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign cnt = cnt_r;

endmodule

// File: rtl/icache_ctrl.sv
// L1 instruction-cache controller: zero-cycle hit lookup against a 2-way tag
// RAM, miss handling through an L2 line request, a one-cycle victim fill and
// a replay access once the tag RAM reports the write done.
module icache_ctrl
    import icache_ctrl_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             if_req,
    input  logic [31:0]      if_addr,
    output logic [31:0]      inst,
    output logic             inst_valid,
    output logic             miss_stall,
    output logic [7:0]       index,
    output logic [20:0]      tag_wd,
    output logic             tag0_rw,
    output logic             tag1_rw,
    output logic             data0_rw,
    output logic             data1_rw,
    output logic [127:0]     data_wd_l2,
    output logic             data_wd_l2_en,
    input  logic [20:0]      tag0_rd,
    input  logic [20:0]      tag1_rd,
    input  logic             lru,
    input  logic             complete,
    input  logic [127:0]     data0_rd,
    input  logic [127:0]     data1_rd,
    output logic             l2_rd_req,
    output logic [27:0]      l2_addr,
    input  logic             l2_rdy,
    input  logic [127:0]     l2_line,
    output logic [CNT_W-1:0] hit_cnt,
    output logic [CNT_W-1:0] miss_cnt
);

    state_e         state_r;
    state_e         state_nxt_s;
    logic [27:0]    miss_line_r;
    logic           victim_r;
    logic           replay_r;
    logic [127:0]   line_buf_r;

    logic           hit0_s;
    logic           hit1_s;
    logic           hit_any_s;
    logic [127:0]   hit_line_s;
    logic           victim_s;
    logic           miss_start_s;
    logic           buf_load_s;
    logic           inst_valid_s;
    logic           hit_inc_s;
    logic           addr_unused_s;

    // Byte offset bits never reach the instruction RAM
    assign addr_unused_s = ^if_addr[1:0];

    // Way lookup against the fetch address; way0 takes priority on a double hit
    always_comb begin
        hit0_s     = tag_hit(tag0_rd, if_addr);
        hit1_s     = tag_hit(tag1_rd, if_addr);
        hit_any_s  = hit0_s || hit1_s;
        hit_line_s = 128'd0;
        if (hit0_s) begin
            hit_line_s = data0_rd;
        end else if (hit1_s) begin
            hit_line_s = data1_rd;
        end else begin
            hit_line_s = 128'd0;
        end
    end

    // Victim choice: fill an invalid way first, otherwise the one not filled last
    always_comb begin
        victim_s = 1'b0;
        if (!tag0_rd[TAG_VALID_BIT]) begin
            victim_s = 1'b0;
        end else if (!tag1_rd[TAG_VALID_BIT]) begin
            victim_s = 1'b1;
        end else begin
            victim_s = lru;
        end
    end

    // RAM set index follows the fetch address only while looking up
    always_comb begin
        index = 8'd0;
        if (state_r == ST_ACCESS) begin
            index = addr_index(if_addr);
        end else begin
            index = miss_line_r[7:0];
        end
    end

    // Next-state and control decode for the miss-handling FSM
    always_comb begin
        state_nxt_s   = state_r;
        miss_stall    = 1'b0;
        l2_rd_req     = 1'b0;
        tag0_rw       = RW_READ;
        tag1_rw       = RW_READ;
        data0_rw      = RW_READ;
        data1_rw      = RW_READ;
        data_wd_l2_en = 1'b0;
        inst_valid_s  = 1'b0;
        miss_start_s  = 1'b0;
        buf_load_s    = 1'b0;
        case (state_r)
            ST_ACCESS: begin
                if (if_req && hit_any_s) begin
                    inst_valid_s = 1'b1;
                end else if (if_req) begin
                    miss_start_s = 1'b1;
                    miss_stall   = 1'b1;
                    state_nxt_s  = ST_L2_REQ;
                end else begin
                    state_nxt_s = ST_ACCESS;
                end
            end
            ST_L2_REQ: begin
                l2_rd_req  = 1'b1;
                miss_stall = 1'b1;
                if (l2_rdy) begin
                    buf_load_s  = 1'b1;
                    state_nxt_s = ST_FILL;
                end else begin
                    state_nxt_s = ST_L2_REQ;
                end
            end
            ST_FILL: begin
                miss_stall    = 1'b1;
                data_wd_l2_en = 1'b1;
                if (victim_r) begin
                    tag1_rw  = RW_WRITE;
                    data1_rw = RW_WRITE;
                end else begin
                    tag0_rw  = RW_WRITE;
                    data0_rw = RW_WRITE;
                end
                state_nxt_s = ST_WAIT;
            end
            ST_WAIT: begin
                miss_stall = 1'b1;
                if (complete) begin
                    state_nxt_s = ST_ACCESS;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            default: begin
                state_nxt_s = ST_ACCESS;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_ACCESS;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Capture the missing line address and its victim way at miss detection
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            miss_line_r <= 28'd0;
            victim_r    <= 1'b0;
        end else if (miss_start_s) begin
            miss_line_r <= if_addr[31:4];
            victim_r    <= victim_s;
        end else begin
            miss_line_r <= miss_line_r;
            victim_r    <= victim_r;
        end
    end

    // Hold the returned L2 line until the fill cycle writes it
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            line_buf_r <= 128'd0;
        end else if (buf_load_s) begin
            line_buf_r <= l2_line;
        end else begin
            line_buf_r <= line_buf_r;
        end
    end

    // Mark the single ACCESS cycle that replays a completed miss
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            replay_r <= 1'b0;
        end else if ((state_r == ST_WAIT) && complete) begin
            replay_r <= 1'b1;
        end else if (state_r == ST_ACCESS) begin
            replay_r <= 1'b0;
        end else begin
            replay_r <= replay_r;
        end
    end

    assign inst_valid = inst_valid_s;
    assign inst       = inst_valid_s ? line_word(hit_line_s, addr_word(if_addr)) : 32'd0;
    assign tag_wd     = {1'b1, miss_line_r[27:8]};
    assign data_wd_l2 = line_buf_r;
    assign l2_addr    = miss_line_r;
    assign hit_inc_s  = inst_valid_s && !replay_r;

    icache_sat_cnt #(.CNT_W(CNT_W)) u_hit_cnt (
        .clk   (clk),
        .rst_n (reset),
        .inc   (hit_inc_s),
        .cnt   (hit_cnt)
    );

    icache_sat_cnt #(.CNT_W(CNT_W)) u_miss_cnt (
        .clk   (clk),
        .rst_n (reset),
        .inc   (miss_start_s),
        .cnt   (miss_cnt)
    );

endmodule
